sisc_exec_unit: RTL and testbench

SISC_EXEC_UNIT -- requirements
Module: sisc_exec_unit

---
 rtl/sisc_pkg.sv | 60 ++++++
 rtl/sisc_exec_alu.sv | 81 ++++++++
 rtl/sisc_exec_unit.sv | 160 ++++++++++++++++
 tb/tb_sisc_exec_unit.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sisc_pkg.sv
// Shared constants for the SISC execute unit: instruction field positions,
// opcodes, ALU function codes, status bit indices and the control FSM states.
package sisc_pkg;

    localparam int OP_HI  = 31;
    localparam int OP_LO  = 28;
    localparam int MM_HI  = 27;
    localparam int MM_LO  = 24;
    localparam int RD_HI  = 23;
    localparam int RD_LO  = 20;
    localparam int RS_HI  = 19;
    localparam int RS_LO  = 16;
    localparam int RT_HI  = 15;
    localparam int RT_LO  = 12;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;

    localparam logic [3:0] OP_NOOP   = 4'h0;
    localparam logic [3:0] OP_REG_OP = 4'h1;
    localparam logic [3:0] OP_REG_IM = 4'h2;
    localparam logic [3:0] OP_BRA    = 4'h4;
    localparam logic [3:0] OP_BRR    = 4'h5;
    localparam logic [3:0] OP_BNE    = 4'h6;
    localparam logic [3:0] OP_BNR    = 4'h7;
    localparam logic [3:0] OP_HLT    = 4'hF;

    localparam logic [3:0] FN_ADD = 4'h0;
    localparam logic [3:0] FN_ADC = 4'h1;
    localparam logic [3:0] FN_SUB = 4'h2;
    localparam logic [3:0] FN_CMP = 4'h3;
    localparam logic [3:0] FN_AND = 4'h4;
    localparam logic [3:0] FN_OR  = 4'h5;
    localparam logic [3:0] FN_XOR = 4'h6;
    localparam logic [3:0] FN_NOT = 4'h7;
    localparam logic [3:0] FN_SHL = 4'h8;
    localparam logic [3:0] FN_SHR = 4'h9;
    localparam logic [3:0] FN_ROL = 4'hA;
    localparam logic [3:0] FN_ROR = 4'hB;

    localparam int ST_C = 3;
    localparam int ST_V = 2;
    localparam int ST_N = 1;
    localparam int ST_Z = 0;

    typedef enum logic [2:0] {
        START0,
        START1,
        FETCH,
        DECODE,
        EXECUTE,
        MEM,
        WRITEBACK,
        HALT
    } state_t;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/sisc_exec_alu.sv
// Combinational ALU: arithmetic with full flags, logic ops, and shifts/rotates
// that exist only when SISC_EXEC_SHIFT_EN is defined (otherwise codes 8-B are reserved).
module sisc_exec_alu
    import sisc_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [3:0]    func,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic          cin,
    output logic [DW-1:0] result,
    output logic [3:0]    sts,
    output logic [3:0]    sts_en,
    output logic          wb_en
);

    logic [DW-1:0] op_b;
    logic          carry_in;
    logic [DW:0]   sum;

`ifdef SISC_EXEC_SHIFT_EN
    logic [4:0]      shamt;
    logic [2*DW-1:0] rot_l;
    logic [2*DW-1:0] rot_r;

    // Rotates come from shifting a doubled copy of the operand.
    always_comb begin
        shamt = b[4:0];
        rot_l = {a, a} << shamt;
        rot_r = {a, a} >> shamt;
    end
`endif

    // SUB and CMP reuse the adder as A + ~B + 1, so C=1 means no borrow.
    always_comb begin
        op_b     = b;
        carry_in = 1'b0;
        case (func)
            FN_ADC:         carry_in = cin;
            FN_SUB, FN_CMP: begin
                op_b     = ~b;
                carry_in = 1'b1;
            end
            default: ;
        endcase
        sum = {1'b0, a} + {1'b0, op_b} + {{DW{1'b0}}, carry_in};
    end

    always_comb begin
        result = '0;
        sts    = '0;
        sts_en = '0;
        wb_en  = 1'b0;
        case (func)
            FN_ADD, FN_ADC, FN_SUB, FN_CMP: begin
                result     = sum[DW-1:0];
                sts_en     = 4'b1111;
                sts[ST_C]  = sum[DW];
                sts[ST_V]  = (a[DW-1] == op_b[DW-1]) && (sum[DW-1] != a[DW-1]);
                wb_en      = (func != FN_CMP);
            end
            FN_AND: begin result = a & b; sts_en = 4'b0011; wb_en = 1'b1; end
            FN_OR:  begin result = a | b; sts_en = 4'b0011; wb_en = 1'b1; end
            FN_XOR: begin result = a ^ b; sts_en = 4'b0011; wb_en = 1'b1; end
            FN_NOT: begin result = ~a;    sts_en = 4'b0011; wb_en = 1'b1; end
`ifdef SISC_EXEC_SHIFT_EN
            FN_SHL: begin result = a << shamt;          sts_en = 4'b0011; wb_en = 1'b1; end
            FN_SHR: begin result = a >> shamt;          sts_en = 4'b0011; wb_en = 1'b1; end
            FN_ROL: begin result = rot_l[2*DW-1:DW];    sts_en = 4'b0011; wb_en = 1'b1; end
            FN_ROR: begin result = rot_r[DW-1:0];       sts_en = 4'b0011; wb_en = 1'b1; end
`endif
            default: ;
        endcase
        if (sts_en[ST_N]) begin
            sts[ST_N] = result[DW-1];
            sts[ST_Z] = (result == '0);
        end
    end

endmodule

// File: rtl/sisc_exec_unit.sv
// SISC execute unit: multi-cycle control FSM, branch resolution and ALU wrapper.
// Shift/rotate functions are enabled by defining SISC_EXEC_SHIFT_EN.
module sisc_exec_unit
    import sisc_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_f,
    input  logic [31:0]   instr,
    input  logic [3:0]    stat,
    input  logic [DW-1:0] rega,
    input  logic [DW-1:0] regb,
    input  logic [DW-1:0] pc_out,
    output logic [DW-1:0] alu_out,
    output logic [3:0]    alu_sts,
    output logic [3:0]    stat_en,
    output logic          rf_we,
    output logic          wb_sel,
    output logic          ir_load,
    output logic          pc_rst,
    output logic          pc_write,
    output logic          pc_sel,
    output logic          br_sel,
    output logic [DW-1:0] br_addr
);

    state_t state_q;
    state_t state_d;

    logic [3:0]  opcode;
    logic [3:0]  mm;
    logic [15:0] imm;
    logic        is_reg;
    logic        is_branch;
    logic        is_abs;
    logic        taken;
    logic [DW-1:0] alu_b;
    logic [DW-1:0] alu_result;
    logic [3:0]    alu_flags;
    logic [3:0]    alu_flags_en;
    logic          alu_wb_en;
    logic [DW-1:0] br_target;
    logic          unused_fields;

    assign opcode = instr[OP_HI:OP_LO];
    assign mm     = instr[MM_HI:MM_LO];
    assign imm    = instr[IMM_HI:IMM_LO];
    // Register indices are consumed by the register file, not here.
    assign unused_fields = ^instr[RD_HI:RS_LO];

    assign is_reg    = (opcode == OP_REG_OP) || (opcode == OP_REG_IM);
    assign is_branch = (opcode == OP_BRA) || (opcode == OP_BRR) ||
                       (opcode == OP_BNE) || (opcode == OP_BNR);
    assign is_abs    = (opcode == OP_BRA) || (opcode == OP_BNE);
    assign alu_b     = (opcode == OP_REG_IM) ? sext16(imm) : regb;

    // mm selects which status bits are tested; BNE/BNR invert the sense.
    always_comb begin
        taken = 1'b0;
        case (opcode)
            OP_BRA, OP_BRR: taken = |(stat & mm);
            OP_BNE, OP_BNR: taken = ~|(stat & mm);
            default: ;
        endcase
    end

    // pc_out already points past this instruction.
    assign br_target = is_abs ? {16'b0, imm} : pc_out + sext16(imm);

    sisc_exec_alu #(.DW(DW)) u_alu (
        .func   (mm),
        .a      (rega),
        .b      (alu_b),
        .cin    (stat[ST_C]),
        .result (alu_result),
        .sts    (alu_flags),
        .sts_en (alu_flags_en),
        .wb_en  (alu_wb_en)
    );

    always_ff @(posedge clk) begin
        if (rst_f) begin
            state_q <= START0;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            START0:    state_d = START1;
            START1:    state_d = FETCH;
            FETCH:     state_d = DECODE;
            DECODE:    state_d = (opcode == OP_HLT) ? HALT : EXECUTE;
            EXECUTE:   state_d = MEM;
            MEM:       state_d = WRITEBACK;
            WRITEBACK: state_d = FETCH;
            HALT:      state_d = HALT;
            default:   state_d = START0;
        endcase
    end

    // Reset overrides the state so outputs are defined before the first edge.
    always_comb begin
        alu_out  = '0;
        alu_sts  = '0;
        stat_en  = '0;
        rf_we    = 1'b0;
        wb_sel   = 1'b0;
        ir_load  = 1'b0;
        pc_rst   = 1'b0;
        pc_write = 1'b0;
        pc_sel   = 1'b0;
        br_sel   = 1'b0;
        br_addr  = '0;
        if (rst_f) begin
            pc_rst = 1'b1;
        end else begin
            case (state_q)
                START0: pc_rst = 1'b1;
                FETCH: begin
                    ir_load  = 1'b1;
                    pc_write = 1'b1;
                end
                EXECUTE: begin
                    if (is_reg) begin
                        alu_out = alu_result;
                        alu_sts = alu_flags;
                        stat_en = alu_flags_en;
                    end
                    if (is_branch) begin
                        br_sel  = is_abs;
                        br_addr = br_target;
                        if (taken) begin
                            pc_write = 1'b1;
                            pc_sel   = 1'b1;
                        end
                    end
                end
                MEM: begin
                    if (is_reg) begin
                        alu_out = alu_result;
                        alu_sts = alu_flags;
                    end
                end
                WRITEBACK: begin
                    if (is_reg) begin
                        alu_out = alu_result;
                        alu_sts = alu_flags;
                        rf_we   = alu_wb_en;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sisc_exec_unit.sv
// Self-checking bench for sisc_exec_unit: per-cycle control vectors and EXECUTE
// data results are queued from a reference model and compared as the DUT steps.
module tb_sisc_exec_unit;

`ifdef SISC_EXEC_SHIFT_EN
    localparam bit SHIFT_EN = 1'b1;
`else
    localparam bit SHIFT_EN = 1'b0;
`endif

    // {stat_en[3:0], rf_we, wb_sel, ir_load, pc_rst, pc_write, pc_sel, br_sel}
    localparam logic [10:0] C_IDLE  = 11'b0000_0000000;
    localparam logic [10:0] C_FETCH = 11'b0000_0010100;
    localparam logic [10:0] C_PCRST = 11'b0000_0001000;

    logic        clk = 1'b0;
    logic        rst_f;
    logic [31:0] instr;
    logic [3:0]  stat;
    logic [31:0] rega;
    logic [31:0] regb;
    logic [31:0] pc_out;
    logic [31:0] alu_out;
    logic [3:0]  alu_sts;
    logic [3:0]  stat_en;
    logic        rf_we;
    logic        wb_sel;
    logic        ir_load;
    logic        pc_rst;
    logic        pc_write;
    logic        pc_sel;
    logic        br_sel;
    logic [31:0] br_addr;
    logic [10:0] ctrl_obs;

    int n_checks = 0;
    int n_errors = 0;

    logic [10:0] exp_q[$];
    logic [69:0] data_q[$];

    sisc_exec_unit #(.DW(32)) dut (
        .clk      (clk),
        .rst_f    (rst_f),
        .instr    (instr),
        .stat     (stat),
        .rega     (rega),
        .regb     (regb),
        .pc_out   (pc_out),
        .alu_out  (alu_out),
        .alu_sts  (alu_sts),
        .stat_en  (stat_en),
        .rf_we    (rf_we),
        .wb_sel   (wb_sel),
        .ir_load  (ir_load),
        .pc_rst   (pc_rst),
        .pc_write (pc_write),
        .pc_sel   (pc_sel),
        .br_sel   (br_sel),
        .br_addr  (br_addr)
    );

    assign ctrl_obs = {stat_en, rf_we, wb_sel, ir_load, pc_rst, pc_write, pc_sel, br_sel};

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic ref_alu(input logic [3:0] fn, input logic [31:0] a, input logic [31:0] b,
                           input logic cin, output logic [31:0] res, output logic [3:0] sts,
                           output logic [3:0] en, output logic wb);
        longint sa;
        longint sb;
        longint sv;
        logic [32:0] u;
        logic [31:0] r;
        int s;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        s   = int'(b[4:0]);
        res = '0;
        sts = '0;
        en  = '0;
        wb  = 1'b0;
        r   = a;
        case (fn)
            4'h0, 4'h1: begin
                u = {1'b0, a} + {1'b0, b} + ((fn == 4'h1) ? {32'b0, cin} : 33'b0);
                res = u[31:0];
                sts[3] = u[32];
                sv = sa + sb + ((fn == 4'h1 && cin) ? 64'sd1 : 64'sd0);
                sts[2] = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
                en = 4'hF;
                wb = 1'b1;
            end
            4'h2, 4'h3: begin
                res = a - b;
                sts[3] = (a >= b);
                sv = sa - sb;
                sts[2] = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
                en = 4'hF;
                wb = (fn == 4'h2);
            end
            4'h4: begin res = a & b; en = 4'h3; wb = 1'b1; end
            4'h5: begin res = a | b; en = 4'h3; wb = 1'b1; end
            4'h6: begin res = a ^ b; en = 4'h3; wb = 1'b1; end
            4'h7: begin res = ~a;    en = 4'h3; wb = 1'b1; end
            4'h8, 4'h9, 4'hA, 4'hB: begin
                if (SHIFT_EN) begin
                    for (int i = 0; i < s; i++) begin
                        case (fn)
                            4'h8:    r = {r[30:0], 1'b0};
                            4'h9:    r = {1'b0, r[31:1]};
                            4'hA:    r = {r[30:0], r[31]};
                            default: r = {r[0], r[31:1]};
                        endcase
                    end
                    res = r;
                    en  = 4'h3;
                    wb  = 1'b1;
                end
            end
            default: ;
        endcase
        if (en != 4'h0) begin
            sts[1] = res[31];
            sts[0] = (res == 32'h0);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        rst_f = 1'b1;
        #1 check("rst_assert_ctrl", 32'(ctrl_obs), 32'(C_PCRST));
        repeat (2) @(posedge clk);
        #1 check("rst_hold_ctrl", 32'(ctrl_obs), 32'(C_PCRST));
        check("rst_hold_data", alu_out | br_addr | {28'b0, alu_sts}, 32'h0);
        @(negedge clk);
        rst_f = 1'b0;
        #1 check("start0_ctrl", 32'(ctrl_obs), 32'(C_PCRST));
        @(negedge clk);
        check("start1_ctrl", 32'(ctrl_obs), 32'(C_IDLE));
    endtask

    task automatic run_instr(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                             input logic [3:0] st, input logic [31:0] pc);
        logic [3:0]  op;
        logic [3:0]  mm;
        logic [15:0] imm;
        logic [31:0] res;
        logic [3:0]  sts;
        logic [3:0]  en;
        logic        wb;
        logic        tk;
        logic        abs_m;
        logic [31:0] tgt;
        logic [10:0] c_exec;
        logic [10:0] c_wb;
        logic [69:0] d;
        logic [10:0] e;
        string       sname[5];
        sname = '{"fetch", "decode", "execute", "mem", "writeback"};
        instr  = ins;
        rega   = a;
        regb   = b;
        stat   = st;
        pc_out = pc;
        op  = ins[31:28];
        mm  = ins[27:24];
        imm = ins[15:0];
        c_exec = C_IDLE;
        c_wb   = C_IDLE;
        d      = '0;
        if (op == 4'h1 || op == 4'h2) begin
            ref_alu(mm, a, (op == 4'h2) ? {{16{imm[15]}}, imm} : b, st[3], res, sts, en, wb);
            c_exec = {en, 7'b0};
            c_wb   = {4'b0, wb, 6'b0};
            d      = {2'd1, res, sts, 32'h0};
        end else if (op >= 4'h4 && op <= 4'h7) begin
            tk    = (op == 4'h4 || op == 4'h5) ? ((st & mm) != 4'h0) : ((st & mm) == 4'h0);
            abs_m = (op == 4'h4 || op == 4'h6);
            tgt   = abs_m ? {16'h0, imm} : pc + {{16{imm[15]}}, imm};
            c_exec = {4'b0, 1'b0, 1'b0, 1'b0, 1'b0, tk, tk, abs_m};
            d      = {2'd2, 32'h0, 4'h0, tgt};
        end
        exp_q.push_back(C_FETCH);
        exp_q.push_back(C_IDLE);
        exp_q.push_back(c_exec);
        exp_q.push_back(C_IDLE);
        exp_q.push_back(c_wb);
        data_q.push_back(d);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            check($sformatf("ctrl_%s_%h", sname[i], ins), 32'(ctrl_obs), 32'(e));
            if (i == 2) begin
                d = data_q.pop_front();
                if (d[69:68] == 2'd1) begin
                    check($sformatf("alu_out_%h", ins), alu_out, d[67:36]);
                    check($sformatf("alu_sts_%h", ins), 32'(alu_sts), 32'(d[35:32]));
                end else if (d[69:68] == 2'd2) begin
                    check($sformatf("br_addr_%h", ins), br_addr, d[31:0]);
                end
            end
        end
    endtask

    task automatic run_hlt(input logic [31:0] ins);
        instr = ins;
        exp_q.push_back(C_FETCH);
        exp_q.push_back(C_IDLE);
        for (int i = 0; i < 20; i++) exp_q.push_back(C_IDLE);
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            check($sformatf("hlt_ctrl_%0d", i), 32'(ctrl_obs), 32'(exp_q.pop_front()));
        end
        check("hlt_data", alu_out | br_addr | {28'b0, alu_sts}, 32'h0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_f  = 1'b1;
        instr  = 32'h0;
        stat   = 4'h0;
        rega   = 32'h0;
        regb   = 32'h0;
        pc_out = 32'h0;
        #1 check("por_ctrl", 32'(ctrl_obs), 32'(C_PCRST));
        do_reset();

        // Arithmetic and flags
        run_instr(32'h10312000, 32'd5,        32'd7,        4'h0, 32'h0);
        run_instr(32'h10312000, 32'hFFFFFFFF, 32'h1,        4'h0, 32'h0);
        run_instr(32'h10312000, 32'h7FFFFFFF, 32'h1,        4'h0, 32'h0);
        run_instr(32'h11312000, 32'd3,        32'd4,        4'h8, 32'h0);
        run_instr(32'h11312000, 32'hFFFFFFFF, 32'h0,        4'h8, 32'h0);
        run_instr(32'h12312000, 32'd3,        32'd5,        4'h0, 32'h0);
        run_instr(32'h12312000, 32'h80000000, 32'h1,        4'h0, 32'h0);
        run_instr(32'h13312000, 32'd9,        32'd9,        4'h0, 32'h0);
        // Logic, immediates, shifts and reserved codes
        run_instr(32'h2431FFF0, 32'h12345678, 32'h0,        4'h0, 32'h0);
        run_instr(32'h15312000, 32'hF0F00000, 32'h0000000F, 4'h0, 32'h0);
        run_instr(32'h16312000, 32'hAAAA5555, 32'hAAAA5555, 4'h0, 32'h0);
        run_instr(32'h17312000, 32'h00000000, 32'h0,        4'h0, 32'h0);
        run_instr(32'h28310004, 32'h80000001, 32'h0,        4'h0, 32'h0);
        run_instr(32'h1B312000, 32'h80000001, 32'h1,        4'h0, 32'h0);
        run_instr(32'h1C312000, 32'h12345678, 32'h1,        4'hF, 32'h0);
        run_instr(32'h2F31FFFF, 32'h12345678, 32'h0,        4'hF, 32'h0);
        // Branches
        run_instr(32'h5100FFFC, 32'h0, 32'h0, 4'h1, 32'h10);
        run_instr(32'h5100FFFC, 32'h0, 32'h0, 4'h0, 32'h10);
        run_instr(32'h68000040, 32'h0, 32'h0, 4'h0, 32'h20);
        run_instr(32'h68000040, 32'h0, 32'h0, 4'h8, 32'h20);
        run_instr(32'h40008123, 32'h0, 32'h0, 4'hF, 32'h20);
        run_instr(32'h70000005, 32'h0, 32'h0, 4'hF, 32'h100);
        run_instr(32'h4600ABCD, 32'h0, 32'h0, 4'h2, 32'h100);
        // NOOP and undefined opcodes
        run_instr(32'h00000000, 32'h1, 32'h2, 4'hF, 32'h0);
        run_instr(32'h3F31FFFF, 32'h1, 32'h2, 4'hF, 32'h0);
        run_instr(32'hC1234567, 32'h1, 32'h2, 4'hF, 32'h0);

        for (int k = 0; k < 24; k++) begin
            logic [3:0] r_op;
            r_op = 4'($urandom_range(0, 7));
            run_instr({r_op, 4'($urandom_range(0, 15)), 8'h31, 16'($urandom)},
                      $urandom, $urandom, 4'($urandom_range(0, 15)), $urandom);
        end

        // Reset in the middle of an instruction
        instr = 32'h10312000;
        repeat (3) @(negedge clk);
        do_reset();
        run_instr(32'h10312000, 32'd100, 32'd23, 4'h0, 32'h0);

        // Halt, then recover by reset
        run_hlt(32'hF5A31234);
        do_reset();
        run_instr(32'h10312000, 32'd1, 32'd1, 4'h0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
